byte_serial_add_arb: RTL and testbench

Two-requester arbiter and sequencer that shares one 8-bit carry-select adder slice to perform WIDTH-bit additions byte-serially, least significant byte first. Requests are granted round-robin. Operands are captured on acceptance and summed over WIDTH/8 cycles through a registered inter-byte carry. The result is presented on a valid/ready response port tagged with the requester ID.

---
 rtl/byte_serial_add_arb_pkg.sv | 31 +++
 rtl/byte_serial_add_arb_if.sv | 42 ++++
 rtl/byte_serial_add_arb_csa_8c.sv | 36 +++
 rtl/byte_serial_add_arb.sv | 121 ++++++++++++
 tb/tb_byte_serial_add_arb.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/byte_serial_add_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : byte_serial_pkg
// Description : Shared types and helpers for the byte-serial adder arbiter.
//               Holds the controller state encoding, the adder slice width,
//               and helpers for the byte count and the byte-index width.
// Revision    : 1.0 - initial release
// ============================================================================
package byte_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 8;

    // Number of adder-slice passes needed for a given operand width.
    function automatic int nb(input int width);
        return width / SLICE_W;
    endfunction

    // Byte index width; kept at least one bit so a 1-byte build still has
    // a legal index register.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_serial_add_arb_if.sv
`default_nettype none
// ============================================================================
// Interface   : byte_serial_add_arb_if
// Description : Request and response bundle for byte_serial_add_arb.
//               master - requesters and response consumer side
//               slave  - arbiter side
//   req_valid[1:0]  per-requester request valid
//   req_ready[1:0]  per-requester accept strobe
//   req_a0/b0       requester 0 operands
//   req_a1/b1       requester 1 operands
//   rsp_valid/ready result handshake
//   rsp_id          owner of the result
//   rsp_sum         (a + b) mod 2^WIDTH
//   rsp_carry       carry out of bit WIDTH-1
// Revision    : 1.0 - initial release
// ============================================================================
interface byte_serial_add_arb_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_b0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] req_b1;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_carry;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry
    );
endinterface
`default_nettype wire

// File: rtl/byte_serial_add_arb_csa_8c.sv
`default_nettype none
// ============================================================================
// Module      : csa_8c
// Description : 8-bit carry-select adder slice with carry-in and carry-out.
//               The low nibble ripples with i_cin; the high nibble is
//               precomputed for both carry values and picked by the
//               low-nibble carry.
//   i_a, i_b   8-bit addends
//   i_cin      carry in
//   o_sum      8-bit sum
//   o_cout     carry out of bit 7
// Revision    : 1.0 - initial release
// ============================================================================
module csa_8c
    import byte_serial_pkg::*;
(
    input  wire logic [SLICE_W-1:0] i_a,
    input  wire logic [SLICE_W-1:0] i_b,
    input  wire logic               i_cin,
    output logic      [SLICE_W-1:0] o_sum,
    output logic                    o_cout
);
    logic [4:0] w_lo;
    logic [4:0] w_hi0;
    logic [4:0] w_hi1;
    logic [4:0] w_hi;

    assign w_lo   = {1'b0, i_a[3:0]} + {1'b0, i_b[3:0]} + {4'b0000, i_cin};
    assign w_hi0  = {1'b0, i_a[7:4]} + {1'b0, i_b[7:4]};
    assign w_hi1  = {1'b0, i_a[7:4]} + {1'b0, i_b[7:4]} + 5'd1;
    assign w_hi   = w_lo[4] ? w_hi1 : w_hi0;

    assign o_sum  = {w_hi[3:0], w_lo[3:0]};
    assign o_cout = w_hi[4];
endmodule
`default_nettype wire

// File: rtl/byte_serial_add_arb.sv
`default_nettype none
// ============================================================================
// Module      : byte_serial_add_arb
// Description : Two-requester round-robin arbiter that time-shares one 8-bit
//               carry-select slice to add WIDTH-bit operands byte-serially,
//               least significant byte first, then returns the result on a
//               valid/ready port tagged with the requester index.
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    byte_serial_add_arb_if.slave (requests in, response out)
// Revision    : 1.0 - initial release
// ============================================================================
module byte_serial_add_arb
    import byte_serial_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic rst_n,
    byte_serial_add_arb_if.slave bus
);
    localparam int NB = nb(WIDTH);
    localparam int KW = idx_w(NB);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic [KW-1:0]      r_k;
    logic               r_c;
    logic               r_prio;
    logic               r_rsp_valid;
    logic               r_id;

    logic               w_grant;
    logic [1:0]         w_grant_vec;
    logic [SLICE_W-1:0] w_a_byte [NB];
    logic [SLICE_W-1:0] w_b_byte [NB];
    logic [SLICE_W-1:0] w_slice_sum;
    logic               w_slice_cout;

    // A lone requester wins outright; on contention the pointer decides.
    assign w_grant     = (bus.req_valid == 2'b11) ? r_prio : bus.req_valid[1];
    assign w_grant_vec = (bus.req_valid == 2'b00) ? 2'b00 :
                         (w_grant ? 2'b10 : 2'b01);

    // rst_n gates the strobe so nothing is accepted while reset is held.
    assign bus.req_ready = (rst_n && (r_state == IDLE)) ? w_grant_vec : 2'b00;

    for (genvar j = 0; j < NB; j++) begin : g_bytes
        assign w_a_byte[j] = r_a[j*SLICE_W +: SLICE_W];
        assign w_b_byte[j] = r_b[j*SLICE_W +: SLICE_W];
    end

    csa_8c u_slice (
        .i_a    (w_a_byte[r_k]),
        .i_b    (w_b_byte[r_k]),
        .i_cin  (r_c),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_k         <= '0;
            r_c         <= 1'b0;
            r_prio      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_id        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid != 2'b00) begin
                        r_a     <= w_grant ? bus.req_a1 : bus.req_a0;
                        r_b     <= w_grant ? bus.req_b1 : bus.req_b0;
                        r_id    <= w_grant;
                        r_prio  <= ~w_grant;
                        r_k     <= '0;
                        r_c     <= 1'b0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    for (int j = 0; j < NB; j++) begin
                        if (r_k == KW'(j)) begin
                            r_sum[j*SLICE_W +: SLICE_W] <= w_slice_sum;
                        end
                    end
                    r_c <= w_slice_cout;
                    if (r_k == KW'(NB - 1)) begin
                        r_k         <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_sum   = r_sum;
    assign bus.rsp_carry = r_c;
    assign bus.rsp_id    = r_id;
endmodule
`default_nettype wire

// File: tb/tb_byte_serial_add_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_serial_add_arb
// Description : Directed self-checking bench for byte_serial_add_arb
//               (WIDTH = 32) with hand-computed expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_serial_add_arb;
    logic clk;
    logic rst_n;
    int   cyc;
    int   vectors;
    int   miscompares;

    byte_serial_add_arb_if #(.WIDTH(32)) bus ();

    byte_serial_add_arb #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Drives one request and follows it to its response with rsp_ready high.
    // Returns at posedge+2 of the first DONE cycle.
    task automatic do_op(input logic [1:0] v, input logic [31:0] a0, b0, a1, b1,
                         input bit keep, output int g, output int acc_cyc,
                         output int lat, output logic [31:0] sum,
                         output logic carry, output logic id,
                         output int rdy_viol, output bit tmo);
        int t;
        tmo = 0; rdy_viol = 0; g = -1; lat = 0; acc_cyc = 0;
        sum = '0; carry = 1'b0; id = 1'b0;
        @(posedge clk); #1;
        bus.req_valid = v;
        bus.req_a0 = a0; bus.req_b0 = b0;
        bus.req_a1 = a1; bus.req_b1 = b1;
        bus.rsp_ready = 1'b1;
        #1;
        t = 0;
        while (bus.req_ready == 2'b00 && t < 20) begin
            @(posedge clk); #2; t++;
        end
        if (bus.req_ready == 2'b00) begin tmo = 1; return; end
        g = bus.req_ready[1] ? 1 : 0;
        acc_cyc = cyc;
        @(posedge clk); #1;
        if (!keep) bus.req_valid = 2'b00;
        #1;
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            if (bus.req_ready !== 2'b00) rdy_viol++;
            @(posedge clk); #2; lat++;
        end
        if (!bus.rsp_valid) begin tmo = 1; return; end
        if (bus.req_ready !== 2'b00) rdy_viol++;
        sum = bus.rsp_sum; carry = bus.rsp_carry; id = bus.rsp_id;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 2'b01;
        bus.rsp_ready = 1'b0;
        #3;
        vectors++;
        if (bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready: got %b expected 00", bus.req_ready); end
        vectors++;
        if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
        vectors++;
        if (bus.rsp_sum !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_sum: got %h expected 00000000", bus.rsp_sum); end
        vectors++;
        if ({bus.rsp_id, bus.rsp_carry} !== 2'b00) begin miscompares++; $display("FAIL reset_id_carry: got %b expected 00", {bus.rsp_id, bus.rsp_carry}); end
        bus.req_valid = 2'b00;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int g, acc, lat, rv; logic [31:0] s; logic c, id; bit tmo;
        // requester 0: FF + 01, nibble and byte carry into byte 1
        do_op(2'b01, 32'h0000_00FF, 32'h0000_0001, 32'h0, 32'h0, 0, g, acc, lat, s, c, id, rv, tmo);
        vectors++;
        if (tmo) begin miscompares++; $display("FAIL r0_timeout: got timeout expected response"); end
        vectors++;
        if (s !== 32'h0000_0100 || c !== 1'b0) begin miscompares++; $display("FAIL r0_sum: got %h/%b expected 00000100/0", s, c); end
        vectors++;
        if (id !== 1'b0 || g != 0) begin miscompares++; $display("FAIL r0_id: got id %b grant %0d expected 0/0", id, g); end
        vectors++;
        if (lat != 5) begin miscompares++; $display("FAIL r0_latency: got %0d expected 5", lat); end
        // requester 1: full wrap with carry out
        do_op(2'b10, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0000_0001, 0, g, acc, lat, s, c, id, rv, tmo);
        vectors++;
        if (tmo || s !== 32'h0000_0000 || c !== 1'b1) begin miscompares++; $display("FAIL r1_sum: got %h/%b expected 00000000/1", s, c); end
        vectors++;
        if (id !== 1'b1 || g != 1) begin miscompares++; $display("FAIL r1_id: got id %b grant %0d expected 1/1", id, g); end
        // carry across several bytes
        do_op(2'b01, 32'h00FF_FF80, 32'h0000_0080, 32'h0, 32'h0, 0, g, acc, lat, s, c, id, rv, tmo);
        vectors++;
        if (tmo || s !== 32'h0100_0000 || c !== 1'b0) begin miscompares++; $display("FAIL carry_chain: got %h/%b expected 01000000/0", s, c); end
        vectors++;
        if (rv != 0) begin miscompares++; $display("FAIL single_ready_busy: got %0d expected 0", rv); end
    endtask

    task automatic test_back_to_back();
        int g, acc, prev_acc, lat, rv; logic [31:0] s; logic c, id; bit tmo;
        int exp_g;
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        prev_acc = 0;
        for (int i = 0; i < 4; i++) begin
            exp_g = i % 2;
            do_op(2'b11, 32'h1234_5678, 32'h1111_1111, 32'h1234_5678, 32'h1111_1111, 1,
                  g, acc, lat, s, c, id, rv, tmo);
            vectors++;
            if (tmo || g != exp_g || id !== exp_g[0]) begin miscompares++; $display("FAIL b2b_grant[%0d]: got %0d id %b expected %0d", i, g, id, exp_g); end
            vectors++;
            if (s !== 32'h2345_6789 || c !== 1'b0) begin miscompares++; $display("FAIL b2b_sum[%0d]: got %h/%b expected 23456789/0", i, s, c); end
            vectors++;
            if (rv != 0) begin miscompares++; $display("FAIL b2b_ready_busy[%0d]: got %0d expected 0", i, rv); end
            if (i > 0) begin
                vectors++;
                if (acc - prev_acc != 6) begin miscompares++; $display("FAIL b2b_spacing[%0d]: got %0d expected 6", i, acc - prev_acc); end
            end
            prev_acc = acc;
        end
        @(posedge clk); #1; bus.req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        int t;
        @(posedge clk); #1;
        bus.req_valid = 2'b10;
        bus.req_a1 = 32'h8000_0000; bus.req_b1 = 32'h8000_0001;
        bus.req_a0 = 32'h0000_0010; bus.req_b0 = 32'h0000_0020;
        bus.rsp_ready = 1'b0;
        #1;
        vectors++;
        if (bus.req_ready !== 2'b10) begin miscompares++; $display("FAIL bp_accept: got %b expected 10", bus.req_ready); end
        @(posedge clk); #1; bus.req_valid = 2'b11; #1;
        t = 0;
        while (!bus.rsp_valid && t < 20) begin @(posedge clk); #2; t++; end
        vectors++;
        if (!bus.rsp_valid) begin miscompares++; $display("FAIL bp_timeout: got no rsp_valid expected response"); end
        vectors++;
        if (bus.rsp_carry !== 1'b1) begin miscompares++; $display("FAIL bp_carry: got %b expected 1", bus.rsp_carry); end
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.rsp_ready = 1'b1;
            vectors++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 32'h0000_0001 || bus.rsp_id !== 1'b1)
                begin miscompares++; $display("FAIL bp_hold[%0d]: got v%b %h id%b expected v1 00000001 id1", i, bus.rsp_valid, bus.rsp_sum, bus.rsp_id); end
            vectors++;
            if (bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL bp_ready[%0d]: got %b expected 00", i, bus.req_ready); end
            @(posedge clk); #2;
        end
        // IDLE now: response gone, contention resolved to requester 0 (prio 0)
        vectors++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL bp_idle: got v%b ready %b expected v0 ready 01", bus.rsp_valid, bus.req_ready); end
        @(posedge clk); #1; bus.req_valid = 2'b00; #1;
        t = 0;
        while (!bus.rsp_valid && t < 20) begin @(posedge clk); #2; t++; end
        vectors++;
        if (bus.rsp_sum !== 32'h0000_0030 || bus.rsp_id !== 1'b0) begin miscompares++; $display("FAIL bp_next: got %h id%b expected 00000030 id0", bus.rsp_sum, bus.rsp_id); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        int t;
        @(posedge clk); #1;
        bus.req_valid = 2'b01;
        bus.req_a0 = 32'h1122_3344; bus.req_b0 = 32'h1111_1111;
        bus.req_a1 = 32'hAAAA_0000; bus.req_b1 = 32'h0000_5555;
        bus.rsp_ready = 1'b1;
        #1;
        vectors++;
        if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL rr_accept: got %b expected 01", bus.req_ready); end
        @(posedge clk); #1; bus.req_valid = 2'b00;   // byte 0
        @(posedge clk);                              // byte 1
        @(posedge clk); #1;                          // byte 2
        rst_n = 1'b0;
        bus.req_valid = 2'b11;
        #1;
        vectors++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== 32'h0) begin miscompares++; $display("FAIL rr_clear: got v%b %h expected v0 00000000", bus.rsp_valid, bus.rsp_sum); end
        vectors++;
        if (bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL rr_ready_low: got %b expected 00", bus.req_ready); end
        @(posedge clk); #2;
        vectors++;
        if (bus.req_ready !== 2'b00) begin miscompares++; $display("FAIL rr_ready_low2: got %b expected 00", bus.req_ready); end
        bus.req_a0 = 32'h0000_0002; bus.req_b0 = 32'h0000_0003;
        #2; rst_n = 1'b1; #1;
        vectors++;
        if (bus.req_ready !== 2'b01) begin miscompares++; $display("FAIL rr_prio0: got %b expected 01", bus.req_ready); end
        @(posedge clk); #1; bus.req_valid = 2'b00; #1;
        t = 1;
        while (!bus.rsp_valid && t < 20) begin @(posedge clk); #2; t++; end
        vectors++;
        if (t != 5) begin miscompares++; $display("FAIL rr_latency: got %0d expected 5", t); end
        vectors++;
        if (bus.rsp_sum !== 32'h0000_0005 || bus.rsp_id !== 1'b0 || bus.rsp_carry !== 1'b0) begin miscompares++; $display("FAIL rr_sum: got %h id%b c%b expected 00000005 id0 c0", bus.rsp_sum, bus.rsp_id, bus.rsp_carry); end
        @(posedge clk); #1;
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        rst_n = 1'b0;
        bus.req_valid = 2'b00; bus.rsp_ready = 1'b0;
        bus.req_a0 = '0; bus.req_b0 = '0; bus.req_a1 = '0; bus.req_b1 = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
